uart_rx_idle_timer: RTL and testbench



---
 rtl/uart_rx_idle_timer_if.sv | 26 ++
 rtl/uart_rx_idle_timer.sv | 65 ++++++
 tb/tb_uart_rx_idle_timer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_idle_timer_if.sv
// uart_rx_idle_timer_if: control, event and status signals of the RX idle timer
interface uart_rx_idle_timer_if #(
  parameter int CNT_W  = 16,
  parameter int TO_W   = 4,
  parameter int BYTE_W = 8
);
  logic              en_i;
  logic              clr_i;
  logic [CNT_W-1:0]  baud_i;
  logic [TO_W-1:0]   to_chars_i;
  logic              rx_start_i;
  logic              rx_done_i;
  logic              rx_timeout_o;
  logic              armed_o;
  logic [BYTE_W-1:0] byte_cnt_o;
  logic [BYTE_W-1:0] frame_len_o;
  logic              cnt_ovf_o;
  modport master (
    output en_i, clr_i, baud_i, to_chars_i, rx_start_i, rx_done_i,
    input  rx_timeout_o, armed_o, byte_cnt_o, frame_len_o, cnt_ovf_o
  );
  modport slave (
    input  en_i, clr_i, baud_i, to_chars_i, rx_start_i, rx_done_i,
    output rx_timeout_o, armed_o, byte_cnt_o, frame_len_o, cnt_ovf_o
  );
endinterface

// File: rtl/uart_rx_idle_timer.sv
// uart_rx_idle_timer: counts RX bytes and times the line gap, pulsing on idle timeout
module uart_rx_idle_timer #(
  parameter int CNT_W     = 16,
  parameter int CHAR_BITS = 10,
  parameter int TO_W      = 4,
  parameter int BYTE_W    = 8
) (
  input logic clk_i,
  input logic rst_ni,
  uart_rx_idle_timer_if.slave bus
);
  localparam int IDX_W = CHAR_BITS > 1 ? $clog2(CHAR_BITS) : 1;
  typedef enum logic [1:0] {IDLE, RECV, ARMED} state_t;
  state_t state, state_d;
  logic [CNT_W-1:0]  bit_cnt, baud_m1;
  logic [IDX_W-1:0]  bit_idx;
  logic [TO_W-1:0]   char_cnt;
  logic [TO_W:0]     char_nxt;
  logic [BYTE_W-1:0] byte_cnt, frame_len;
  logic              tmo, ovf;
  logic              clear, bit_end, char_end, expire, fire, run, sat;
  assign clear    = bus.clr_i || !bus.en_i;
  assign baud_m1  = bus.baud_i == '0 ? '0 : bus.baud_i - CNT_W'(1);
  // >= rather than == so threshold changes while armed apply without a restart
  assign bit_end  = bit_cnt >= baud_m1;
  assign char_end = bit_end && bit_idx >= IDX_W'(CHAR_BITS - 1);
  assign char_nxt = {1'b0, char_cnt} + (TO_W + 1)'(1);
  assign sat      = &byte_cnt;
  always_comb begin
    expire  = state == ARMED && char_end && char_nxt >= {1'b0, bus.to_chars_i};
    fire    = expire && !clear && !bus.rx_done_i && !bus.rx_start_i;
    run     = state == ARMED && !clear && !bus.rx_done_i && !bus.rx_start_i && !expire;
    state_d = clear           ? IDLE :
              bus.rx_done_i   ? (bus.to_chars_i != '0 ? ARMED : IDLE) :
              bus.rx_start_i  ? RECV :
              expire          ? IDLE : state;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bit_cnt   <= '0;
      bit_idx   <= '0;
      char_cnt  <= '0;
      byte_cnt  <= '0;
      frame_len <= '0;
      tmo       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      bit_cnt   <= run ? (bit_end ? '0 : bit_cnt + CNT_W'(1)) : '0;
      bit_idx   <= run ? (char_end ? '0 : bit_end ? bit_idx + IDX_W'(1) : bit_idx) : '0;
      char_cnt  <= run ? (char_end ? char_nxt[TO_W-1:0] : char_cnt) : '0;
      tmo       <= fire;
      byte_cnt  <= clear || fire ? '0 :
                   bus.rx_done_i ? (sat ? byte_cnt : byte_cnt + BYTE_W'(1)) : byte_cnt;
      ovf       <= clear || fire ? 1'b0 : ovf | (bus.rx_done_i && sat);
      frame_len <= fire ? byte_cnt : frame_len;
    end
  assign bus.rx_timeout_o = tmo;
  assign bus.armed_o      = state == ARMED;
  assign bus.byte_cnt_o   = byte_cnt;
  assign bus.frame_len_o  = frame_len;
  assign bus.cnt_ovf_o    = ovf;
endmodule

// File: tb/tb_uart_rx_idle_timer.sv
// tb_uart_rx_idle_timer: directed and randomized checks against a deadline-based model
module tb_uart_rx_idle_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_rx_idle_timer_if bus();
  uart_rx_idle_timer dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  int vectors = 0;
  int errs = 0;
  logic   m_armed, m_pulse, m_ovf;
  int     m_bytes, m_frame;
  longint m_cyc = 0, m_dead = 0;
  logic [18:0] got;
  assign got = {bus.rx_timeout_o, bus.armed_o, bus.byte_cnt_o, bus.frame_len_o, bus.cnt_ovf_o};
  function automatic logic [18:0] exp_v();
    return {m_pulse, m_armed, 8'(m_bytes), 8'(m_frame), m_ovf};
  endfunction
  task automatic model_reset();
    m_armed = 0; m_pulse = 0; m_ovf = 0; m_bytes = 0; m_frame = 0;
  endtask
  // one clock with the given event inputs; the model works from absolute expiry deadlines
  task automatic step(input logic d = 0, input logic s = 0, input logic c = 0, input logic e = 1);
    bus.rx_done_i = d; bus.rx_start_i = s; bus.clr_i = c; bus.en_i = e;
    @(posedge clk);
    m_cyc++;
    m_pulse = 0;
    if (!e || c) begin
      m_armed = 0; m_bytes = 0; m_ovf = 0;
    end else if (d) begin
      if (m_bytes == 255) m_ovf = 1; else m_bytes++;
      m_armed = bus.to_chars_i != 0;
      m_dead = m_cyc + longint'(bus.to_chars_i) * 10 * (bus.baud_i == 0 ? 1 : longint'(bus.baud_i));
    end else if (s) begin
      m_armed = 0;
    end else if (m_armed && m_cyc == m_dead) begin
      m_pulse = 1; m_frame = m_bytes; m_bytes = 0; m_ovf = 0; m_armed = 0;
    end
    #1;
  endtask
  task automatic test_reset();
    bus.en_i = 1; bus.clr_i = 0; bus.rx_done_i = 0; bus.rx_start_i = 0;
    bus.baud_i = 4; bus.to_chars_i = 2;
    model_reset();
    #12;
    if (got !== 19'd0) begin errs++; $display("FAIL reset_state got=%h exp=%h", got, 19'd0); end
    vectors++;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (got !== exp_v()) begin errs++; $display("FAIL reset_idle got=%h exp=%h", got, exp_v()); end
      vectors++;
    end
  endtask
  task automatic test_basic();
    int at = 0, n = 0;
    bus.baud_i = 4; bus.to_chars_i = 2;
    step(1);
    for (int k = 1; k <= 100; k++) begin
      step();
      if (got !== exp_v()) begin errs++; $display("FAIL basic_cycle k=%0d got=%h exp=%h", k, got, exp_v()); end
      vectors++;
      if (bus.rx_timeout_o) begin n++; at = k; end
    end
    if (at !== 80 || n !== 1) begin errs++; $display("FAIL basic_pulse at=%0d count=%0d exp at=80 count=1", at, n); end
    vectors++;
    if (bus.frame_len_o !== 8'd1 || bus.byte_cnt_o !== 8'd0) begin
      errs++; $display("FAIL basic_frame frame_len=%0d byte_cnt=%0d exp 1/0", bus.frame_len_o, bus.byte_cnt_o);
    end
    vectors++;
  endtask
  task automatic test_back_to_back();
    int at = 0, n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      for (int k = 1; k < 40 && i < 4; k++) begin
        step();
        if (got !== exp_v()) begin errs++; $display("FAIL b2b_gap i=%0d got=%h exp=%h", i, got, exp_v()); end
        vectors++;
        if (bus.rx_timeout_o) n++;
      end
    end
    for (int k = 1; k <= 100; k++) begin
      step();
      if (got !== exp_v()) begin errs++; $display("FAIL b2b_tail k=%0d got=%h exp=%h", k, got, exp_v()); end
      vectors++;
      if (bus.rx_timeout_o) begin n++; at = k; end
    end
    if (at !== 80 || n !== 1 || bus.frame_len_o !== 8'd5) begin
      errs++; $display("FAIL b2b_pulse at=%0d count=%0d frame_len=%0d exp 80/1/5", at, n, bus.frame_len_o);
    end
    vectors++;
  endtask
  task automatic test_restart_edge();
    int at = 0, n = 0;
    step(1);
    for (int k = 1; k < 80; k++) begin
      step();
      if (got !== exp_v()) begin errs++; $display("FAIL edge_wait k=%0d got=%h exp=%h", k, got, exp_v()); end
      vectors++;
    end
    step(0, 1);
    if (bus.rx_timeout_o !== 1'b0 || bus.armed_o !== 1'b0) begin
      errs++; $display("FAIL edge_start timeout=%b armed=%b exp 0/0", bus.rx_timeout_o, bus.armed_o);
    end
    vectors++;
    for (int k = 0; k < 20; k++) begin
      step();
      if (got !== exp_v()) begin errs++; $display("FAIL edge_recv got=%h exp=%h", got, exp_v()); end
      vectors++;
    end
    step(1);
    for (int k = 1; k <= 100; k++) begin
      step();
      if (got !== exp_v()) begin errs++; $display("FAIL edge_rearm k=%0d got=%h exp=%h", k, got, exp_v()); end
      vectors++;
      if (bus.rx_timeout_o) begin n++; at = k; end
    end
    if (at !== 80 || n !== 1) begin errs++; $display("FAIL edge_pulse at=%0d count=%0d exp 80/1", at, n); end
    vectors++;
  endtask
  task automatic test_disable();
    int n = 0, fl;
    bus.to_chars_i = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      repeat (5) step();
    end
    for (int k = 0; k < 200; k++) begin
      step();
      if (got !== exp_v()) begin errs++; $display("FAIL dis_cycle got=%h exp=%h", got, exp_v()); end
      vectors++;
      if (bus.rx_timeout_o) n++;
    end
    if (n !== 0 || bus.byte_cnt_o !== 8'd3) begin
      errs++; $display("FAIL dis_count pulses=%0d byte_cnt=%0d exp 0/3", n, bus.byte_cnt_o);
    end
    vectors++;
    fl = m_frame;
    step(0, 0, 1);
    if (bus.byte_cnt_o !== 8'd0 || bus.frame_len_o !== 8'(fl)) begin
      errs++; $display("FAIL dis_clr byte_cnt=%0d frame_len=%0d exp 0/%0d", bus.byte_cnt_o, bus.frame_len_o, fl);
    end
    vectors++;
  endtask
  task automatic test_saturation();
    int at = 0;
    bus.baud_i = 4; bus.to_chars_i = 2;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (got !== exp_v()) begin errs++; $display("FAIL sat_byte i=%0d got=%h exp=%h", i, got, exp_v()); end
      vectors++;
      repeat ($urandom_range(0, 20)) step();
    end
    if (bus.byte_cnt_o !== 8'd255 || bus.cnt_ovf_o !== 1'b1) begin
      errs++; $display("FAIL sat_level byte_cnt=%0d ovf=%b exp 255/1", bus.byte_cnt_o, bus.cnt_ovf_o);
    end
    vectors++;
    for (int k = 0; k < 100 && at == 0; k++) begin
      step();
      if (bus.rx_timeout_o) at = 1;
    end
    if (at !== 1 || bus.frame_len_o !== 8'd255 || bus.cnt_ovf_o !== 1'b0) begin
      errs++; $display("FAIL sat_timeout seen=%0d frame_len=%0d ovf=%b exp 1/255/0", at, bus.frame_len_o, bus.cnt_ovf_o);
    end
    vectors++;
  endtask
  task automatic test_async_reset();
    int at = 0, n = 0;
    bus.baud_i = 4; bus.to_chars_i = 2;
    step(1);
    repeat (40) step();
    #2 rst_n = 0;
    #1;
    if (got !== 19'd0) begin errs++; $display("FAIL arst_async got=%h exp=%h", got, 19'd0); end
    vectors++;
    model_reset();
    #1 rst_n = 1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (got !== exp_v()) begin errs++; $display("FAIL arst_after got=%h exp=%h", got, exp_v()); end
      vectors++;
      if (bus.rx_timeout_o) n++;
    end
    if (n !== 0) begin errs++; $display("FAIL arst_pulse count=%0d exp 0", n); end
    vectors++;
    bus.baud_i = 0; bus.to_chars_i = 3;
    step(1);
    for (int k = 1; k <= 50; k++) begin
      step();
      if (got !== exp_v()) begin errs++; $display("FAIL baud0_cycle k=%0d got=%h exp=%h", k, got, exp_v()); end
      vectors++;
      if (bus.rx_timeout_o) at = k;
    end
    if (at !== 30) begin errs++; $display("FAIL baud0_pulse at=%0d exp 30", at); end
    vectors++;
  endtask
  task automatic test_random();
    int r;
    for (int k = 0; k < 3000; k++) begin
      if (!m_armed && $urandom_range(0, 7) == 0) begin
        bus.baud_i = 16'($urandom_range(0, 3));
        bus.to_chars_i = 4'($urandom_range(0, 3));
      end
      r = $urandom_range(0, 199);
      step(r < 4 || r == 6, r == 4 || r == 5 || r == 6, r == 7, r != 8);
      if (got !== exp_v()) begin errs++; $display("FAIL random k=%0d got=%h exp=%h", k, got, exp_v()); end
      vectors++;
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_restart_edge();
    test_disable();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
